// File: rtl/arith_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// start/busy/done handshake; results held until the next completed division.
module arith_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             take;
    logic [WIDTH-1:0] rem_step;
    logic             last;
    logic             unused_diff;

    // The extra top bit of diff is the borrow; the partial remainder stays below
    // the divisor, so a kept difference always fits in WIDTH bits.
    assign shifted     = {rem_q, dvd_q[WIDTH-1]};
    assign diff        = {1'b0, shifted} - {2'b00, dvs_q};
    assign take        = ~diff[WIDTH+1];
    assign rem_step    = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign last        = (cnt_q == CntW'(WIDTH - 1));
    assign unused_diff = diff[WIDTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            StRun: begin
                rem_d = rem_step;
                quo_d = {quo_q[WIDTH-2:0], take};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    quotient_d  = {quo_q[WIDTH-2:0], take};
                    remainder_d = rem_step;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_seq_divider.sv
// Directed bench for arith_seq_divider (WIDTH=8): handshake timing, edge cases,
// ignored restarts, mid-run reset and a seeded sweep checked against a simple model.
module tb_arith_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arith_seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns edges from
    // acceptance to the done cycle (-1 on timeout) and the captured results.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat,
                           output logic [7:0] q, output logic [7:0] r, output logic z);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat      = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        if (lat >= 0) begin
            tick();
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic div_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] eq, input logic [7:0] er, input logic ez,
                             input int elat);
        int         lat;
        logic [7:0] q, r;
        logic       z;
        run_div(a, b, lat, q, r, z);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_dbz"}, 32'(z), 32'(ez));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ndone;
        int         dedge;
        int         lat;
        logic [7:0] dq, dr, a, b, q, r;
        logic       z;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        // 10/3 with explicit cycle-by-cycle handshake checks
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd3;
        tick();
        start = 1'b0;
        chk("t1_busy_after_e0", 32'(busy), 32'd1);
        ndone = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("t1_early_done", 32'(ndone), 32'd0);
        tick();
        chk("t1_done_after_e8", 32'(done), 32'd1);
        chk("t1_busy_in_done", 32'(busy), 32'd1);
        chk("t1_q", 32'(quotient), 32'd3);
        chk("t1_r", 32'(remainder), 32'd1);
        chk("t1_dbz", 32'(div_by_zero), 32'd0);
        tick();
        chk("t1_busy_after_e9", 32'(busy), 32'd0);
        chk("t1_done_after_e9", 32'(done), 32'd0);

        // back-to-back, each issued on the first idle cycle
        div_check("b2b_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        div_check("b2b_200_255", 8'd200, 8'd255, 8'd0, 8'd200, 1'b0, 8);
        div_check("b2b_0_7", 8'd0, 8'd7, 8'd0, 8'd0, 1'b0, 8);

        div_check("dz_7_0", 8'd7, 8'd0, 8'd255, 8'd7, 1'b1, 0);
        div_check("after_dz_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8);

        // 100/7 with an ignored second start and operand change mid-run
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        tick();
        chk("held_q_mid_run", 32'(quotient), 32'd4);
        chk("held_r_mid_run", 32'(remainder), 32'd1);
        tick();
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        tick();
        start = 1'b0;
        ndone = 0;
        dedge = -1;
        dq    = '0;
        dr    = '0;
        for (int e = 4; e < 16; e++) begin
            tick();
            if (done) begin
                ndone++;
                dedge = e;
                dq    = quotient;
                dr    = remainder;
            end
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_done_edge", 32'(dedge), 32'd8);
        chk("ign_q", 32'(dq), 32'd14);
        chk("ign_r", 32'(dr), 32'd2);

        // 250/13 aborted by reset at cycle 4
        start    = 1'b1;
        dividend = 8'd250;
        divisor  = 8'd13;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        div_check("restart_250_13", 8'd250, 8'd13, 8'd19, 8'd3, 1'b0, 8);

        div_check("msb_255_128", 8'd255, 8'd128, 8'd1, 8'd127, 1'b0, 8);
        div_check("big_254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 8);

        // seeded sweep against a reference model and the division invariant
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = (i % 4 == 0) ? (8'h80 | 8'($urandom)) : 8'($urandom);
            run_div(a, b, lat, q, r, z);
            if (b == 8'd0) begin
                chk("rnd_dz_lat", 32'(lat), 32'd0);
                chk("rnd_dz_q", 32'(q), 32'd255);
                chk("rnd_dz_r", 32'(r), 32'(a));
                chk("rnd_dz_flag", 32'(z), 32'd1);
            end else begin
                chk("rnd_lat", 32'(lat), 32'd8);
                chk("rnd_q", 32'(q), 32'(a / b));
                chk("rnd_r", 32'(r), 32'(a % b));
                chk("rnd_inv", 32'(q) * 32'(b) + 32'(r), 32'(a));
                chk("rnd_r_lt_d", 32'(r < b), 32'd1);
                chk("rnd_dbz", 32'(z), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
